// File: rtl/msg_uart_tx.sv
// msg_uart_tx: walks a 16-entry character ROM and sends each byte as an async serial frame.
// Optional even-parity bit (8E1) when MSG_UART_PARITY_EN is defined; otherwise 8N1.
`default_nettype none

module msg_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int MSG_LEN      = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  localparam logic [15:0] c_BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  c_IDX_LAST  = 4'(MSG_LEN - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_idx;
  logic [7:0]  r_char;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_nxt;
  logic [15:0] r_baud;
  logic        r_tx;
  logic        w_tx_nxt;
  logic        r_done;
  logic        w_msg_end;
  logic        w_baud_end;
  logic        w_in_frame;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_msg_end   = 1'b0;
    w_bit_nxt   = r_bit;
    w_baud_end  = (r_baud == c_BAUD_LAST);
    w_in_frame  = (r_state == S_START) || (r_state == S_DATA) ||
                  (r_state == S_PARITY) || (r_state == S_STOP);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_bit_nxt = 3'd0;
        if (rom_data == 8'h00) begin
          w_state_nxt = S_IDLE;
          w_msg_end   = 1'b1;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_bit_nxt = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
`ifdef MSG_UART_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
      S_PARITY: begin
        if (w_baud_end) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          if (r_idx == c_IDX_LAST) begin
            w_state_nxt = S_IDLE;
            w_msg_end   = 1'b1;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Line level is computed from the next state so tx leaves a flop, glitch-free.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = r_char[w_bit_nxt];
      S_PARITY: w_tx_nxt = ^r_char;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx  <= 4'd0;
      r_char <= 8'd0;
      r_bit  <= 3'd0;
      r_baud <= 16'd0;
      r_tx   <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_done <= w_msg_end;
      r_tx   <= w_tx_nxt;
      r_bit  <= w_bit_nxt;
      // Reload at every bit boundary so bit timing never accumulates error.
      if (w_in_frame && !w_baud_end) begin
        r_baud <= r_baud + 16'd1;
      end else begin
        r_baud <= 16'd0;
      end
      if ((r_state == S_IDLE) && start) begin
        r_idx <= 4'd0;
      end else if ((r_state == S_STOP) && w_baud_end && (r_idx != c_IDX_LAST)) begin
        r_idx <= r_idx + 4'd1;
      end
      if (r_state == S_FETCH) begin
        r_char <= rom_data;
      end
    end
  end

  assign rom_addr = r_idx;
  assign tx       = r_tx;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_msg_uart_tx.sv
// tb_msg_uart_tx: directed, table-driven bench for msg_uart_tx against a model of the default ROM.
`default_nettype none

module tb_msg_uart_tx;

`ifdef MSG_UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int C_A = 1 + (10 + P) * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_a, start_b, start_c;
  logic [3:0] addr_a, addr_b, addr_c;
  logic [7:0] data_a, data_b, data_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;

  function automatic logic [7:0] rom(input logic [3:0] a);
    case (a)
      4'd0: return 8'h45;  4'd1: return 8'h4E;  4'd2: return 8'h47;
      4'd3: return 8'h49;  4'd4: return 8'h4E;  4'd5: return 8'h45;
      4'd6: return 8'h45;  4'd7: return 8'h52;  4'd8: return 8'h49;
      4'd9: return 8'h4E;  4'd10: return 8'h47;
      default: return 8'h00;
    endcase
  endfunction

  assign data_a = rom(addr_a);
  assign data_b = rom(addr_b);
  assign data_c = rom(addr_c);

  msg_uart_tx #(.CLKS_PER_BIT(4), .MSG_LEN(11)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .rom_addr(addr_a), .rom_data(data_a),
    .tx(tx_a), .busy(busy_a), .done(done_a));
  msg_uart_tx #(.CLKS_PER_BIT(4), .MSG_LEN(16)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .rom_addr(addr_b), .rom_data(data_b),
    .tx(tx_b), .busy(busy_b), .done(done_b));
  msg_uart_tx #(.CLKS_PER_BIT(2), .MSG_LEN(1)) u_dut_c (
    .clk(clk), .reset(reset), .start(start_c), .rom_addr(addr_c), .rom_data(data_c),
    .tx(tx_c), .busy(busy_c), .done(done_c));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] ch;
  } frame_vec_t;

  typedef struct {
    int   cyc;
    logic tx;
    logic busy;
    logic done;
  } wave_vec_t;

  frame_vec_t fv[11];
  wave_vec_t  wv[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  function automatic logic get_tx(input int w);
    case (w) 0: return tx_a; 1: return tx_b; default: return tx_c; endcase
  endfunction
  function automatic logic get_busy(input int w);
    case (w) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
  endfunction
  function automatic logic get_done(input int w);
    case (w) 0: return done_a; 1: return done_b; default: return done_c; endcase
  endfunction
  function automatic logic [3:0] get_addr(input int w);
    case (w) 0: return addr_a; 1: return addr_b; default: return addr_c; endcase
  endfunction

  task automatic decode(input int w, output logic [7:0] b, output logic [3:0] a);
    int cpb;
    int t;
    cpb = (w == 2) ? 2 : 4;
    b = 8'h00;
    a = 4'h0;
    t = 0;
    while (get_tx(w) !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      timeout("frame_start");
    end else begin
      repeat (cpb / 2) @(negedge clk);
      check("start_bit", 32'(get_tx(w)), 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (cpb) @(negedge clk);
        b[i] = get_tx(w);
      end
      a = get_addr(w);
`ifdef MSG_UART_PARITY_EN
      repeat (cpb) @(negedge clk);
      check("parity_bit", 32'(get_tx(w)), 32'(^b));
`endif
      repeat (cpb) @(negedge clk);
      check("stop_bit", 32'(get_tx(w)), 32'd1);
    end
  endtask

  task automatic wait_done(input int w, input int bound, output logic seen);
    int t;
    t = 0;
    while (get_done(w) !== 1'b1 && t < bound) begin
      @(negedge clk);
      t++;
    end
    seen = (get_done(w) === 1'b1);
    if (!seen) timeout("done_wait");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic [3:0] a;
    logic       seen;
    int         f;
    int         k;

    fv[0] = '{4'd0, 8'h45};  fv[1] = '{4'd1, 8'h4E};  fv[2]  = '{4'd2, 8'h47};
    fv[3] = '{4'd3, 8'h49};  fv[4] = '{4'd4, 8'h4E};  fv[5]  = '{4'd5, 8'h45};
    fv[6] = '{4'd6, 8'h45};  fv[7] = '{4'd7, 8'h52};  fv[8]  = '{4'd8, 8'h49};
    fv[9] = '{4'd9, 8'h4E};  fv[10] = '{4'd10, 8'h47};

    // 0x45 at two clocks per bit, LSB first: 1,0,1,0,0,0,1,0
    wv[0]  = '{1, 1'b1, 1'b1, 1'b0};   wv[1]  = '{2, 1'b0, 1'b1, 1'b0};
    wv[2]  = '{3, 1'b0, 1'b1, 1'b0};   wv[3]  = '{4, 1'b1, 1'b1, 1'b0};
    wv[4]  = '{6, 1'b0, 1'b1, 1'b0};   wv[5]  = '{8, 1'b1, 1'b1, 1'b0};
    wv[6]  = '{10, 1'b0, 1'b1, 1'b0};  wv[7]  = '{12, 1'b0, 1'b1, 1'b0};
    wv[8]  = '{16, 1'b1, 1'b1, 1'b0};  wv[9]  = '{18, 1'b0, 1'b1, 1'b0};
    wv[10] = '{21 + 2 * P, 1'b1, 1'b1, 1'b0};
    wv[11] = '{22 + 2 * P, 1'b1, 1'b0, 1'b1};
    wv[12] = '{23 + 2 * P, 1'b1, 1'b0, 1'b0};

    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      check("reset_tx", 32'(get_tx(w)), 32'd1);
      check("reset_busy", 32'(get_busy(w)), 32'd0);
      check("reset_done", 32'(get_done(w)), 32'd0);
      check("reset_addr", 32'(get_addr(w)), 32'd0);
    end

    // Full default message
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    f = cyc;
    check("fetch_busy", 32'(busy_a), 32'd1);
    check("fetch_tx", 32'(tx_a), 32'd1);
    for (int i = 0; i < 11; i++) begin
      decode(0, b, a);
      check("msg_char", 32'(b), 32'(fv[i].ch));
      check("msg_addr", 32'(a), 32'(fv[i].addr));
    end
    wait_done(0, 20, seen);
    if (seen) begin
      check("done_latency", 32'(cyc - f), 32'(11 * C_A));
      check("done_busy_low", 32'(busy_a), 32'd0);
      @(negedge clk);
      check("done_one_cycle", 32'(done_a), 32'd0);
    end

    // MSG_LEN=16: null byte at slot 11 ends the message
    do_reset();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    f = cyc;
    for (int i = 0; i < 11; i++) begin
      decode(1, b, a);
      check("long_char", 32'(b), 32'(fv[i].ch));
    end
    k = 0;
    while (addr_b !== 4'd11 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (addr_b !== 4'd11) begin
      timeout("null_fetch");
    end else begin
      check("null_fetch_cycle", 32'(cyc - f), 32'(11 * C_A));
      check("null_fetch_busy", 32'(busy_b), 32'd1);
      check("null_fetch_tx", 32'(tx_b), 32'd1);
      @(negedge clk);
      check("null_done", 32'(done_b), 32'd1);
      check("null_busy", 32'(busy_b), 32'd0);
      check("null_tx", 32'(tx_b), 32'd1);
      repeat (3) @(negedge clk);
      check("null_no_frame", 32'(tx_b), 32'd1);
    end

    // start held high: restarts back-to-back, mid-frame requests ignored
    do_reset();
    start_a = 1'b1;
    @(negedge clk);
    decode(0, b, a);
    check("held_first_char", 32'(b), 32'h45);
    decode(0, b, a);
    check("held_second_char", 32'(b), 32'h4E);
    wait_done(0, 1000, seen);
    if (seen) begin
      check("held_done_busy", 32'(busy_a), 32'd0);
      @(negedge clk);
      check("held_refetch_busy", 32'(busy_a), 32'd1);
      check("held_refetch_addr", 32'(addr_a), 32'd0);
      check("held_refetch_done", 32'(done_a), 32'd0);
      decode(0, b, a);
      check("held_restart_char", 32'(b), 32'h45);
    end
    start_a = 1'b0;

    // Async reset during DATA bit 3 of the 5th character
    do_reset();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4 * C_A + 18) @(negedge clk);
    check("pre_reset_busy", 32'(busy_a), 32'd1);
    check("pre_reset_addr", 32'(addr_a), 32'd4);
    #1 reset = 1'b1;
    #1;
    check("async_tx", 32'(tx_a), 32'd1);
    check("async_busy", 32'(busy_a), 32'd0);
    check("async_addr", 32'(addr_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    decode(0, b, a);
    check("post_reset_char", 32'(b), 32'h45);
    check("post_reset_addr", 32'(a), 32'd0);

    // MSG_LEN=1, CLKS_PER_BIT=2 waveform
    do_reset();
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    k = 0;
    for (int c = 1; c <= 23 + 2 * P; c++) begin
      if (c > 1) @(negedge clk);
      if (k < 13 && wv[k].cyc == c) begin
        check("short_tx", 32'(tx_c), 32'(wv[k].tx));
        check("short_busy", 32'(busy_c), 32'(wv[k].busy));
        check("short_done", 32'(done_c), 32'(wv[k].done));
        k++;
      end
      check("short_addr", 32'(addr_c), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/msg_uart_tx.md
# msg_uart_tx

Message sequencer and serial transmitter that sits directly downstream of the 16-entry character ROM. On a start request it walks the ROM address space from 0, fetches each ASCII byte, and sends it as an 8N1 asynchronous serial frame on `tx`. It stops after a fixed message length or at the first null byte. It presents a busy/done handshake to the controlling logic.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range is 2..65535.
- `MSG_LEN`, default 11: maximum characters per message. Legal range is 1..16. The default sends "ENGINEERING".

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: message request; sampled only in IDLE.
- `rom_addr`  out  4: registered address to the ROM.
- `rom_data`  in  8: combinational ROM output for `rom_addr`.
- `tx`  out  1: serial line; idle high.
- `busy`  out  1: high from the first FETCH through the end of the last stop bit.
- `done`  out  1: one-cycle pulse when the message ends.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `rom_addr`=0; the state machine is in IDLE, the character index is 0, and the bit and baud counters are 0.
- Reset is asynchronous. Asserting it mid-frame forces `tx` high and returns to IDLE immediately. No partial frame resumes after reset.
- States are IDLE, FETCH, START, DATA, PARITY (only when the macro is defined), and STOP.
- IDLE:
  - `busy`=0 and `tx`=1.
  - If `start`=1, clear the index, set `rom_addr`=0, and go to FETCH.
- FETCH (one cycle, `busy`=1):
  - `rom_addr` already equals the index.
  - If `rom_data`==8'h00, end the message with no frame sent.
  - Otherwise latch `rom_data` into the shift register and go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - Send 8 bits LSB first, each bit held for `CLKS_PER_BIT` cycles.
  - A 3-bit counter tracks the bit position; after bit 7, go to PARITY or STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles. Then:
  - If index==`MSG_LEN`-1, end the message.
  - Otherwise increment the index, update `rom_addr`, and go to FETCH.
- End of message: go to IDLE. `done`=1 for exactly the first IDLE cycle, and `busy` falls in that same cycle.
- `start` is ignored while `busy`=1; requests are not queued. `start` seen during the `done` cycle launches a new message.
- `rom_addr` is stable for the whole character, including FETCH through STOP.
- The index is 4 bits wide. With `MSG_LEN`=16 it reaches 15 and the message ends; it never wraps.

## Timing
- `start` sampled at edge 0 gives FETCH in cycle 1, and `tx` falls in cycle 2.
- Each character takes 1 + 10·`CLKS_PER_BIT` cycles (1 + 11·`CLKS_PER_BIT` with parity).
- A full default message takes 11·161 = 1771 busy cycles. `done` then pulses in cycle 1772.
- A null terminator in character slot k ends the message 1 cycle after slot k's FETCH.
- The baud counter reloads at every bit boundary, so there is no cumulative drift.

## Configuration
- `MSG_UART_PARITY_EN`:
  - Defined: a PARITY state follows DATA and sends one even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles. The frame becomes 8E1.
  - Undefined: there is no PARITY state and the frame is 8N1.

## Test plan
- Default ROM, `CLKS_PER_BIT`=4, pulse `start`:
  - `tx` decodes 0x45,0x4E,0x47,0x49,0x4E,0x45,0x45,0x52,0x49,0x4E,0x47 in order.
  - `done` pulses once, exactly 11·41 cycles after FETCH begins.
- `MSG_LEN`=16 with the default ROM: 11 frames are sent, then the null byte at address 11 ends the message. `done` arrives 1 cycle after that FETCH, and address 11 produces no start bit.
- `start` held high throughout: the message restarts back-to-back, and a FETCH follows each `done` cycle. `start` pulses mid-frame are ignored and the frame is undisturbed.
- `reset` asserted during DATA bit 3 of the 5th character: `tx`=1, `busy`=0, and `rom_addr`=0 with no clock edge. A following `start` begins again at address 0.
- `MSG_LEN`=1 with `CLKS_PER_BIT`=2: one frame carrying 0x45; `busy` lasts 21 cycles.
- With `MSG_UART_PARITY_EN` defined: the parity bits for "E,N,G" are 1,0,0, and each frame is 11 bits long.
